pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the IF stage; successor to the fixed 32-bit PC register.
//  Selects the next fetch address from flush redirect, pending/live branch redirect or sequential step.
//  Holds a branch that arrives while fetch is stalled, so a stall never loses it.
//  Adds a fetch valid/ready handshake, a configurable reset vector and misaligned-target detection.
// PARAMETERS
//  ADDR_W    32            PC / address width in bits
//  RESET_PC  {ADDR_W{1'b0}} first fetch address after reset
//  STEP      4             sequential increment in bytes; power of two; also the alignment unit
//  STALL_W   6             width of pipeline stall vector; only bit 0 (IF stage) is used here
// PORTS
//  clk                      in   1        clock, all state updates on rising edge
//  rst                      in   1        synchronous reset, active-high
//  stall                    in   STALL_W  pipeline stall vector; stall[0]=1 freezes PC
//  flush                    in   1        exception/eret redirect, highest priority
//  new_pc                   in   ADDR_W   flush target
//  branch_flag_i            in   1        ID-stage branch taken
//  branch_target_address_i  in   ADDR_W   ID-stage branch target
//  fetch_ready              in   1        instruction memory accepts the current pc
//  pc                       out  ADDR_W   current fetch address (registered)
//  ce                       out  1        instruction memory chip enable (registered)
//  fetch_valid              out  1        pc is a valid fetch request this cycle
//  misalign_o               out  1        one-cycle pulse: redirect target was misaligned
//  misalign_addr_o          out  ADDR_W   raw misaligned target, held until next pulse
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, ce=0, state=IDLE, pend_valid=0, misalign_o=0, misalign_addr_o=0.
//  rst dominates every other input, including mid-hold; pending branch is discarded.
//  States: IDLE -> RUN on first edge with rst=0 (ce<=1, pc stays RESET_PC).
//   RUN -> HOLD when branch_flag_i=1 and adv=0 and flush=0: latch pend_addr<=branch target.
//   HOLD -> RUN when adv=1 (pc<=pend_addr, pend_valid<=0) or flush=1 (pending dropped).
//   In HOLD, a new branch_flag_i overwrites pend_addr (latest branch wins).
//  fetch_valid = ce & ~stall[0] & ~flush (combinational); 0 in IDLE.
//  adv = fetch_valid & fetch_ready: the current pc has been accepted.
//  Next-pc priority per edge (state != IDLE):
//   1 flush=1                    -> pc<=new_pc (regardless of stall/ready; clears pending)
//   2 adv & pend_valid           -> pc<=pend_addr
//   3 adv & branch_flag_i        -> pc<=branch_target_address_i
//   4 adv                        -> pc<=pc+STEP, modulo 2^ADDR_W (wraps to 0)
//   5 otherwise                  -> pc holds
//  Same-cycle flush and branch: flush wins, branch is not latched.
//  Alignment: any redirect target (1,2,3) with addr[log2(STEP)-1:0]!=0 -> pc loads target with
//   those bits cleared; misalign_o=1 next cycle, misalign_addr_o=raw target. Sequential never misaligns.
//  Latency: redirect visible on pc one cycle after the edge that samples it; no bubbles inserted.
// TESTING
//  Reset/start: RESET_PC=32'hBFC00000, rst 2 cycles then 0 -> ce=1 next cycle, pc=BFC00000, then BFC00004, ...08.
//  Branch under stall: stall[0]=1 while branch_flag_i=1 tgt=0x100 for 1 cycle, release 3 cycles later -> pc=0x100 on first adv.
//  Flush vs branch: flush=1 new_pc=0x380 with branch_flag_i=1 tgt=0x200 same cycle -> pc=0x380, no later jump to 0x200.
//  Backpressure: fetch_ready=0 for 4 cycles -> pc holds, fetch_valid stays 1; no increment until ready.
//  Misalign: branch tgt=0x1002, STEP=4 -> pc=0x1000, misalign_o pulse 1 cycle, misalign_addr_o=0x1002.
//  Wrap: pc=32'hFFFFFFFC, adv -> pc=0; rst asserted while in HOLD -> pc=RESET_PC, pending cleared.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: picks flush / pending branch / live branch /
// sequential next address, parks a branch seen under stall, and flags misaligned targets.
module pc_gen #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                STEP     = 4,
  parameter int                STALL_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              fetch_valid,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);

  // state | meaning
  // IDLE  | out of reset, memory disabled, first edge enables fetch
  // RUN   | fetching, no branch pending
  // HOLD  | branch seen while pc not accepted; target parked in pend_addr_q
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] mis_addr_q, mis_addr_d;
  logic              ce_q, ce_d;
  logic              mis_q, mis_d;
  logic              adv;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              unused_stall;

  // only the IF-stage bit of the stall vector matters here
  assign unused_stall = ^stall;

  assign fetch_valid = ce_q & ~stall[0] & ~flush;
  assign adv         = fetch_valid & fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pend_addr_q <= '0;
      mis_addr_q  <= '0;
      ce_q        <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      mis_addr_q  <= mis_addr_d;
      ce_q        <= ce_d;
      mis_q       <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    mis_addr_d  = mis_addr_q;
    ce_d        = ce_q;
    mis_d       = 1'b0;
    redirect    = 1'b0;
    target      = pc_q;

    unique case (state_q)
      IDLE: begin
        state_d = RUN;
        ce_d    = 1'b1;
      end
      RUN: begin
        if (flush) begin
          redirect = 1'b1;
          target   = new_pc;
        end else if (adv && branch_flag_i) begin
          redirect = 1'b1;
          target   = branch_target_address_i;
        end else if (adv) begin
          pc_d = pc_q + STEP_V;
        end else if (branch_flag_i) begin
          state_d     = HOLD;
          pend_addr_d = branch_target_address_i;
        end
      end
      HOLD: begin
        if (flush) begin
          redirect = 1'b1;
          target   = new_pc;
          state_d  = RUN;
        end else if (adv) begin
          // the parked branch outranks a branch arriving in the same cycle
          redirect = 1'b1;
          target   = pend_addr_q;
          state_d  = RUN;
        end else if (branch_flag_i) begin
          pend_addr_d = branch_target_address_i;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_d = target & ~ALIGN_MASK;
      if (|(target & ALIGN_MASK)) begin
        mis_d      = 1'b1;
        mis_addr_d = target;
      end
    end
  end

  assign pc              = pc_q;
  assign ce              = ce_q;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/start, backpressure, stalled branch, flush priority,
// misalignment, pending overwrite, wrap, and reset while holding a branch.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        ce;
  logic        fetch_valid;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  int tests  = 0;
  int failed = 0;

  pc_gen #(
    .ADDR_W  (32),
    .RESET_PC(32'hBFC0_0000),
    .STEP    (4),
    .STALL_W (6)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall                  (stall),
    .flush                  (flush),
    .new_pc                 (new_pc),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .fetch_ready            (fetch_ready),
    .pc                     (pc),
    .ce                     (ce),
    .fetch_valid            (fetch_valid),
    .misalign_o             (misalign_o),
    .misalign_addr_o        (misalign_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0; fetch_ready = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, 32'hBFC0_0000);
    chk("rst_ce", {31'd0, ce}, 32'd0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst_misaddr", misalign_addr_o, 32'd0);

    rst = 1'b0;
    tick();
    chk("start_ce", {31'd0, ce}, 32'd1);
    chk("start_pc", pc, 32'hBFC0_0000);
    chk("start_fv", {31'd0, fetch_valid}, 32'd1);
    tick(); chk("seq_pc1", pc, 32'hBFC0_0004);
    tick(); chk("seq_pc2", pc, 32'hBFC0_0008);

    fetch_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_pc", pc, 32'hBFC0_0008);
      chk("bp_fv", {31'd0, fetch_valid}, 32'd1);
    end
    fetch_ready = 1'b1;
    tick(); chk("bp_release", pc, 32'hBFC0_000C);

    stall = 6'd1; branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    #1 chk("stall_fv", {31'd0, fetch_valid}, 32'd0);
    tick(); chk("stall_hold0", pc, 32'hBFC0_000C);
    branch_flag_i = 1'b0;
    tick(); chk("stall_hold1", pc, 32'hBFC0_000C);
    tick(); chk("stall_hold2", pc, 32'hBFC0_000C);
    stall = 6'd0;
    tick(); chk("stall_branch", pc, 32'h100);
    tick(); chk("stall_after", pc, 32'h104);

    flush = 1'b1; new_pc = 32'h380; branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
    #1 chk("flush_fv", {31'd0, fetch_valid}, 32'd0);
    tick(); chk("flush_pc", pc, 32'h380);
    flush = 1'b0; branch_flag_i = 1'b0;
    tick(); chk("flush_seq1", pc, 32'h384);
    tick(); chk("flush_seq2", pc, 32'h388);

    branch_flag_i = 1'b1; branch_target_address_i = 32'h1002;
    tick();
    chk("mis_pc", pc, 32'h1000);
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_addr", misalign_addr_o, 32'h1002);
    branch_flag_i = 1'b0;
    tick();
    chk("mis_seq", pc, 32'h1004);
    chk("mis_end", {31'd0, misalign_o}, 32'd0);
    chk("mis_addr_held", misalign_addr_o, 32'h1002);

    stall = 6'd1; branch_flag_i = 1'b1; branch_target_address_i = 32'h2000;
    tick();
    branch_target_address_i = 32'h3001;
    tick(); chk("hold_pc", pc, 32'h1004);
    branch_flag_i = 1'b0; stall = 6'd0;
    tick();
    chk("latest_pc", pc, 32'h3000);
    chk("latest_mis", {31'd0, misalign_o}, 32'd1);
    chk("latest_addr", misalign_addr_o, 32'h3001);

    stall = 6'd1; branch_flag_i = 1'b1; branch_target_address_i = 32'h4000;
    tick();
    branch_flag_i = 1'b0; flush = 1'b1; new_pc = 32'h500;
    tick();
    chk("hflush_pc", pc, 32'h500);
    chk("hflush_mis", {31'd0, misalign_o}, 32'd0);
    flush = 1'b0; stall = 6'd0;
    tick(); chk("hflush_drop", pc, 32'h504);

    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick(); chk("wrap_top", pc, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick(); chk("wrap_zero", pc, 32'h0);
    tick(); chk("wrap_next", pc, 32'h4);

    stall = 6'd1; branch_flag_i = 1'b1; branch_target_address_i = 32'h600;
    tick();
    branch_flag_i = 1'b0; rst = 1'b1;
    tick();
    chk("hrst_pc", pc, 32'hBFC0_0000);
    chk("hrst_ce", {31'd0, ce}, 32'd0);
    chk("hrst_misaddr", misalign_addr_o, 32'd0);
    rst = 1'b0; stall = 6'd0;
    tick();
    chk("hrst_start", pc, 32'hBFC0_0000);
    chk("hrst_ce1", {31'd0, ce}, 32'd1);
    tick(); chk("hrst_nopend", pc, 32'hBFC0_0004);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
